// File: rtl/tdm_demux_pkg.sv
// Shared constants and state encoding for the 16-slot TDM demultiplexer.
package tdm_demux_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = 4;

  // Index of the slot whose beat completes a frame.
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux1_4.sv
// 1-to-4 one-hot decoder with enable; all outputs low when disabled.
module demux1_4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  // Raise exactly the selected output while enabled.
  always_comb begin
    y = 4'b0000;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux16.sv
// Serial 16-slot TDM frame demultiplexer: collects one bit per valid beat
// into a shadow register and publishes each completed frame on dout.
module tdm_demux16
  import tdm_demux_pkg::*;
#(
  parameter bit REQUIRE_SOF = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 sof,
  output logic [NUM_SLOTS-1:0] dout,
  output logic                 frame_valid,
  output logic [SLOT_W-1:0]    slot,
  output logic                 locked,
  output logic                 sync_err
);

  state_t                 state;
  state_t                 state_nx;
  logic [SLOT_W-1:0]      slot_nx;
  logic [SLOT_W-1:0]      wr_slot;
  logic                   wr_req;
  logic                   fv_nx;
  logic                   se_nx;
  logic [3:0]             grp_en;
  logic [NUM_SLOTS-1:0]   wr_en;
  // Slot 15 is never stored: its bit goes straight into dout with the
  // other fifteen, so the shadow only holds slots 0..14.
  logic [NUM_SLOTS-2:0]   shadow;

  // Two-level decoder tree turning the write slot into one-hot enables.
  demux1_4 u_dec_hi (
    .en  (wr_req),
    .sel (wr_slot[3:2]),
    .y   (grp_en)
  );

  for (genvar g = 0; g < 4; g++) begin : g_dec_lo
    demux1_4 u_dec_lo (
      .en  (grp_en[g]),
      .sel (wr_slot[1:0]),
      .y   (wr_en[4*g +: 4])
    );
  end

  // Next-state, slot and pulse decisions for the current beat.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    wr_req   = 1'b0;
    wr_slot  = slot;
    fv_nx    = 1'b0;
    se_nx    = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (sof) begin
            wr_req   = 1'b1;
            wr_slot  = '0;
            slot_nx  = SLOT_W'(1);
            state_nx = LOCKED;
          end
        end
        LOCKED: begin
          if (sof && (slot != '0)) begin
            // Early sof: drop the partial frame and restart at slot 0.
            se_nx   = 1'b1;
            wr_req  = 1'b1;
            wr_slot = '0;
            slot_nx = SLOT_W'(1);
          end else if (REQUIRE_SOF && !sof && (slot == '0)) begin
            // Missing sof on a frame boundary: lose lock, drop the beat.
            se_nx    = 1'b1;
            slot_nx  = '0;
            state_nx = HUNT;
          end else begin
            wr_req  = 1'b1;
            slot_nx = slot + SLOT_W'(1);
            fv_nx   = (slot == LAST_SLOT);
          end
        end
        default: begin
          state_nx = HUNT;
        end
      endcase
    end
  end

  // Control state and registered outputs; dout loads on the slot-15 beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      locked      <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      dout        <= '0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      locked      <= (state_nx == LOCKED);
      frame_valid <= fv_nx;
      sync_err    <= se_nx;
      if (wr_en[NUM_SLOTS-1]) begin
        dout <= {din, shadow};
      end
    end
  end

  // Shadow bits capture din only where the decoder tree enables them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (wr_en[i]) begin
          shadow[i] <= din;
        end
      end
    end
  end

endmodule

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 Parameter REQUIRE_SOF, default 0: when 1, every slot-0 beat in LOCKED SHALL carry sof.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port din  input  1  serial TDM data bit of the current slot.
REQ-005 Port din_valid  input  1  din/sof qualifier; one beat = one slot.
REQ-006 Port sof  input  1  start-of-frame marker, meaningful only with din_valid, marks slot 0.
REQ-007 Port dout  output  16  last complete frame, bit i = slot i.
REQ-008 Port frame_valid  output  1  one-cycle pulse when dout updates.
REQ-009 Port slot  output  4  next expected slot index.
REQ-010 Port locked  output  1  high in LOCKED state.
REQ-011 Port sync_err  output  1  one-cycle pulse on framing violation.

Function
REQ-012 The FSM SHALL have exactly two states, HUNT and LOCKED; reset state HUNT.
REQ-013 In HUNT, beats without sof SHALL be discarded with no output change; a beat with sof SHALL write din to shadow bit 0, set slot=1, and enter LOCKED.
REQ-014 In LOCKED, each beat SHALL write din to shadow bit [slot], then increment slot modulo 16.
REQ-015 Cycles with din_valid=0 SHALL hold all state and outputs, except that frame_valid and sync_err SHALL return to 0.
REQ-016 On the slot-15 beat, dout SHALL load {din, shadow[14:0]} on that same edge, and frame_valid SHALL be 1 for exactly the following cycle; latency is one edge from the slot-15 sample.
REQ-017 dout SHALL hold its value between completed frames; partial frames SHALL never reach dout.
REQ-018 A LOCKED beat with sof while slot≠0 SHALL pulse sync_err, discard the partial frame, and treat the beat as slot 0 (shadow bit 0 = din, slot=1, stay LOCKED).
REQ-019 With REQUIRE_SOF=0, a LOCKED slot-0 beat without sof SHALL be accepted normally.
REQ-020 With REQUIRE_SOF=1, a LOCKED slot-0 beat without sof SHALL pulse sync_err, discard the beat, set slot=0, and enter HUNT.
REQ-021 Back-to-back frames (slot-15 beat followed directly by slot-0 beat) SHALL be accepted with no lost beat.
REQ-022 Shadow write enables SHALL be one-hot on valid beats and all-zero otherwise.

Reset
REQ-023 rst_n=0 SHALL immediately force dout=16'h0000, frame_valid=0, sync_err=0, slot=0, locked=0, shadow=0, state=HUNT, regardless of clk.
REQ-024 Reset mid-frame SHALL discard the partial frame; after release, the block SHALL require sof to lock.
REQ-025 All outputs SHALL be driven directly from registers.

Structure
REQ-026 Package tdm_demux_pkg SHALL hold NUM_SLOTS=16, SLOT_W=4, and the state enum {HUNT, LOCKED}.
REQ-027 Sub-module demux1_4 (1-to-4 one-hot decoder with enable) SHALL be instantiated five times as a two-level tree: one level on slot[3:2], four on slot[1:0], producing the 16 shadow write enables.

Verification
REQ-028 Reset, sof on first of 16 consecutive beats carrying 16'hA5C3 LSB-first -> frame_valid single pulse after 16th beat, dout=16'hA5C3, locked=1, slot=0.
REQ-029 Same frame with din_valid low for 3 cycles between each beat -> dout=16'hA5C3, exactly one frame_valid pulse, no output change during gaps.
REQ-030 REQUIRE_SOF=0, frames 16'h1234 then 16'hFFFF back-to-back, second without sof -> two pulses 16 cycles apart, dout 16'h1234 then 16'hFFFF.
REQ-031 Locked, sof asserted at slot 7, then 15 more beats of 16'h00FF -> sync_err pulse at slot 7 beat, no frame_valid for partial frame, then dout=16'h00FF.
REQ-032 rst_n low at slot 9 -> dout=0, locked=0, slot=0 immediately; beats without sof after release produce no frame_valid.
REQ-033 REQUIRE_SOF=1, slot-0 beat without sof -> sync_err pulse, locked=0, dout unchanged, slot=0.
